// File: rtl/fp_sub_pkg.sv
// Shared binary32 constants and field layout for the FP subtract leaf.
// Rounding mode is selected in fp_sub_op by FP_SUB_RNE_EN.
package fp_sub_pkg;

   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp32_t;

endpackage

// File: rtl/fp_lzc.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
// Purely combinational, used for post-subtract normalization.
module fp_lzc (
   input  logic [23:0] val,
   output logic [4:0]  cnt
);

   always_comb begin
      cnt = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (val[i]) cnt = 5'(23 - i);
      end
   end

endmodule

// File: rtl/fp_sub_op.sv
// Registered binary32 subtractor: out = para1 - para2, flush-to-zero.
// Define FP_SUB_RNE_EN for round-to-nearest-even; default truncates.
module fp_sub_op
   import fp_sub_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] para1,
   input  logic [31:0] para2,
   output logic [31:0] out,
   output logic        under_overflow,
   output logic        zero
);

   localparam logic signed [9:0] E_TOP = 10'(EXP_MAX);

   fp32_t a_in, b_in, big, sml;
   logic a_nan, a_inf, b_nan, b_inf;
   logic [30:0] key_a, key_b;
   logic [23:0] sig_a, sig_b;
   logic [7:0] d;
   logic [26:0] a_ext, b_sh, diff, m;
   logic [53:0] wide;
   logic [27:0] sum;
   logic [4:0] lz;
   logic eff_sub, rnd_up, exact_zero;
   logic signed [9:0] e_n, e_f;
   logic [24:0] mr;
   logic [22:0] frac;
   logic [31:0] res;
   logic res_uo;

   assign a_in = para1;
   assign b_in = {~para2[31], para2[30:0]};

   assign a_nan = (&a_in.exp) & (|a_in.frac);
   assign a_inf = (&a_in.exp) & ~(|a_in.frac);
   assign b_nan = (&b_in.exp) & (|b_in.frac);
   assign b_inf = (&b_in.exp) & ~(|b_in.frac);

   // Denormals compare as zero so they can never win the swap
   assign key_a = (a_in.exp == '0) ? '0 : {a_in.exp, a_in.frac};
   assign key_b = (b_in.exp == '0) ? '0 : {b_in.exp, b_in.frac};

   assign {big, sml} = (key_b > key_a) ? {b_in, a_in} : {a_in, b_in};

   assign sig_a = (big.exp == '0) ? '0 : {1'b1, big.frac};
   assign sig_b = (sml.exp == '0) ? '0 : {1'b1, sml.frac};

   assign d     = big.exp - sml.exp;
   assign a_ext = {sig_a, 3'b000};
   assign wide  = {sig_b, 3'b000, 27'b0} >> d;
   assign b_sh  = (d >= 8'd26) ? {26'b0, |sig_b}
                               : {wide[53:28], |wide[27:0]};

   assign eff_sub = big.sign ^ sml.sign;
   assign sum     = {1'b0, a_ext} + {1'b0, b_sh};
   assign diff    = a_ext - b_sh;

   fp_lzc u_lzc (
      .val (diff[26:3]),
      .cnt (lz)
   );

   always_comb begin
      m   = sum[26:0];
      e_n = $signed({2'b00, big.exp});
      if (eff_sub) begin
         m   = diff << lz;
         e_n = $signed({2'b00, big.exp}) - $signed({5'b0, lz});
      end else if (sum[27]) begin
         m   = {sum[27:2], |sum[1:0]};
         e_n = $signed({2'b00, big.exp}) + 10'sd1;
      end
   end

   assign exact_zero = (m == '0);

`ifdef FP_SUB_RNE_EN
   assign rnd_up = m[2] & (m[1] | m[0] | m[3]);
`else
   assign rnd_up = 1'b0;
`endif

   assign mr   = {1'b0, m[26:3]} + {24'b0, rnd_up};
   assign e_f  = e_n + $signed({9'b0, mr[24]});
   assign frac = mr[24] ? mr[23:1] : mr[22:0];

   always_comb begin
      res    = '0;
      res_uo = 1'b0;
      if (a_nan | b_nan) begin
         res = QNAN;
      end else if (a_inf & b_inf) begin
         res = (a_in.sign != b_in.sign) ? QNAN
                                        : {a_in.sign, POS_INF[30:0]};
      end else if (a_inf) begin
         res = {a_in.sign, POS_INF[30:0]};
      end else if (b_inf) begin
         res = {b_in.sign, POS_INF[30:0]};
      end else if (exact_zero) begin
         // Only (-0) - (+0) keeps a negative zero
         res = {big.sign & sml.sign, 31'b0};
      end else if (e_f >= E_TOP) begin
         res    = {big.sign, POS_INF[30:0]};
         res_uo = 1'b1;
      end else if (e_f <= 10'sd0) begin
         res    = {big.sign, 31'b0};
         res_uo = 1'b1;
      end else begin
         res = {big.sign, e_f[7:0], frac};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out            <= '0;
         under_overflow <= 1'b0;
         zero           <= 1'b0;
      end else begin
         out            <= res;
         under_overflow <= res_uo;
         zero           <= (res[30:0] == '0);
      end
   end

endmodule

// File: tb/tb_fp_sub_op.sv
// Bench for fp_sub_op: directed table, reset sequence, random stream.
// Reference model works on exact wide integers, then rounds once.
module tb_fp_sub_op;

   typedef struct packed {
      logic [31:0] o;
      logic        uo;
      logic        z;
   } res_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      res_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] para1, para2;
   logic [31:0] out;
   logic        under_overflow, zero;

   int errors = 0;
   int checks = 0;

   logic  have_pend = 1'b0;
   res_t  pend;
   string pend_name;

   fp_sub_op dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .para1          (para1),
      .para2          (para2),
      .out            (out),
      .under_overflow (under_overflow),
      .zero           (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic res_t mk(input logic [31:0] o, input logic uo);
      res_t r;
      r.o  = o;
      r.uo = uo;
      r.z  = (o[30:0] == 31'd0);
      return r;
   endfunction

   // Exact value = mag * 2^-149 for normal inputs
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b);
      logic sa, sb, sr;
      logic [7:0] ea, eb;
      logic [22:0] fa, fb;
      logic [299:0] ma, mb, r;
      logic [24:0] mant;
      int p, k, e;
      logic a_nan, b_nan, a_inf, b_inf;
`ifdef FP_SUB_RNE_EN
      logic [299:0] rem, half;
`endif
      sa = a[31]; ea = a[30:23]; fa = a[22:0];
      sb = ~b[31]; eb = b[30:23]; fb = b[22:0];
      a_nan = (ea == 8'hFF) && (fa != 0);
      b_nan = (eb == 8'hFF) && (fb != 0);
      a_inf = (ea == 8'hFF) && (fa == 0);
      b_inf = (eb == 8'hFF) && (fb == 0);
      if (a_nan || b_nan) return mk(32'h7FC00000, 1'b0);
      if (a_inf && b_inf)
         return mk((sa == sb) ? {sa, 31'h7F800000} : 32'h7FC00000, 1'b0);
      if (a_inf) return mk({sa, 31'h7F800000}, 1'b0);
      if (b_inf) return mk({sb, 31'h7F800000}, 1'b0);
      ma = (ea == 0) ? '0 : (300'({1'b1, fa}) << (ea - 1));
      mb = (eb == 0) ? '0 : (300'({1'b1, fb}) << (eb - 1));
      if (sa == sb) begin
         r = ma + mb; sr = sa;
      end else if (ma >= mb) begin
         r = ma - mb; sr = sa;
      end else begin
         r = mb - ma; sr = sb;
      end
      if (r == 0) return mk({sa & sb, 31'd0}, 1'b0);
      p = 0;
      for (int i = 0; i < 300; i++) if (r[i]) p = i;
      if (p >= 23) begin
         k = p - 23;
         mant = 25'(r >> k);
`ifdef FP_SUB_RNE_EN
         if (k > 0) begin
            rem  = r & ((300'(1) << k) - 300'(1));
            half = 300'(1) << (k - 1);
            if (rem > half || (rem == half && mant[0])) mant = mant + 25'd1;
         end
`endif
      end else begin
         mant = 25'(r << (23 - p));
      end
      e = p - 22;
      if (mant[24]) begin
         e = e + 1;
         mant = mant >> 1;
      end
      if (e >= 255) return mk({sr, 31'h7F800000}, 1'b1);
      if (e <= 0) return mk({sr, 31'd0}, 1'b1);
      return mk({sr, e[7:0], mant[22:0]}, 1'b0);
   endfunction

   task automatic check(input string nm, input res_t got, input res_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got out=%08h uo=%b zero=%b, want out=%08h uo=%b zero=%b",
                  nm, got.o, got.uo, got.z, want.o, want.uo, want.z);
      end
   endtask

   // One pair per cycle: check last cycle's pair, then drive the next
   task automatic cycle(input logic [31:0] a, input logic [31:0] b,
                        input res_t want, input string nm);
      @(negedge clk);
      if (have_pend) check(pend_name, {out, under_overflow, zero}, pend);
      para1 = a;
      para2 = b;
      pend = want;
      pend_name = nm;
      have_pend = 1'b1;
   endtask

   task automatic flush();
      @(negedge clk);
      if (have_pend) check(pend_name, {out, under_overflow, zero}, pend);
      have_pend = 1'b0;
   endtask

   vec_t tbl[16];

   initial begin
      logic [31:0] a, b;
      logic [7:0] ea8, eb8;
      int kind;

      tbl[0]  = '{32'h3F800000, 32'h3F800000, mk(32'h00000000, 1'b0)};
      tbl[1]  = '{32'h3F800000, 32'h40000000, mk(32'hBF800000, 1'b0)};
      tbl[2]  = '{32'h3F800000, 32'hBF800000, mk(32'h40000000, 1'b0)};
      tbl[3]  = '{32'h3F800001, 32'h3F800000, mk(32'h34000000, 1'b0)};
      tbl[4]  = '{32'h40490FDB, 32'h40400000, mk(32'h3E10FDB0, 1'b0)};
      tbl[5]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, mk(32'h7F800000, 1'b1)};
      tbl[6]  = '{32'h00800001, 32'h00800000, mk(32'h00000000, 1'b1)};
      tbl[7]  = '{32'h7F800000, 32'h7F800000, mk(32'h7FC00000, 1'b0)};
      tbl[8]  = '{32'h3F800000, 32'h7F800000, mk(32'hFF800000, 1'b0)};
`ifdef FP_SUB_RNE_EN
      tbl[9]  = '{32'h3F800000, 32'h33000000, mk(32'h3F800000, 1'b0)};
`else
      tbl[9]  = '{32'h3F800000, 32'h33000000, mk(32'h3F7FFFFF, 1'b0)};
`endif
      tbl[10] = '{32'h80000000, 32'h00000000, mk(32'h80000000, 1'b0)};
      tbl[11] = '{32'h7FC00001, 32'h3F800000, mk(32'h7FC00000, 1'b0)};
      tbl[12] = '{32'hFF800000, 32'h7F800000, mk(32'hFF800000, 1'b0)};
      tbl[13] = '{32'h7F800000, 32'h3F800000, mk(32'h7F800000, 1'b0)};
      tbl[14] = '{32'h00000001, 32'h00000000, mk(32'h00000000, 1'b0)};
      tbl[15] = '{32'hC0400000, 32'hBF800000, mk(32'hC0000000, 1'b0)};

      rst_n = 1'b1;
      para1 = 32'h41000000;
      para2 = 32'h3F800000;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_init", {out, under_overflow, zero}, '0);
      rst_n = 1'b1;

      foreach (tbl[i])
         cycle(tbl[i].a, tbl[i].b, tbl[i].exp,
               $sformatf("vec%0d %08h-%08h", i, tbl[i].a, tbl[i].b));
      flush();

      // Reset in the middle of a stream clears outputs at once
      cycle(32'h41000000, 32'h3F800000, mk(32'h40E00000, 1'b0), "pre_rst");
      @(posedge clk);
      #1 check(pend_name, {out, under_overflow, zero}, pend);
      have_pend = 1'b0;
      para1 = 32'h3F800000;
      para2 = 32'h3F800000;
      #1 rst_n = 1'b0;
      #1 check("reset_mid", {out, under_overflow, zero}, '0);
      @(negedge clk);
      check("reset_hold", {out, under_overflow, zero}, '0);
      rst_n = 1'b1;
      cycle(32'h40400000, 32'h3F800000, mk(32'h40000000, 1'b0), "post_rst");
      flush();

      for (int n = 0; n < 400; n++) begin
         kind = $urandom_range(0, 7);
         ea8 = 8'($urandom_range(1, 254));
         a = {1'($urandom), ea8, 23'($urandom)};
         case (kind)
            0, 1, 2: begin
               eb8 = ea8 + 8'($urandom_range(0, 4)) - 8'd2;
               b = {1'($urandom), eb8, 23'($urandom)};
            end
            3: b = a ^ (32'(1) << $urandom_range(0, 3)) ^ {1'($urandom), 31'd0};
            4: b = {1'($urandom), 8'($urandom_range(0, 255)), 23'($urandom)};
            5: b = {1'($urandom), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00,
                    ($urandom_range(0, 1) == 1) ? 23'd0 : 23'($urandom)};
            6: begin
               a = {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
               b = {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)};
            end
            default: begin
               a = {1'($urandom), 8'($urandom_range(1, 30)), 23'($urandom)};
               b = {1'($urandom), 8'($urandom_range(1, 30)), 23'($urandom)};
            end
         endcase
         cycle(a, b, model(a, b), $sformatf("rand%0d %08h-%08h", n, a, b));
      end
      flush();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
